fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch pipeline register between the program counter / instruction ROM and the decode stage. Each cycle it captures the ROM word addressed by the current program counter, together with that PC value. It also handles:
- decode stalls, by holding the PC and its own outputs;
- taken-branch flushes, by inserting a bubble;
- program start and halt, via a run/halt FSM;
- a saturating cycle count, used for benchmarking.

Parameters:
- D, 12, program-counter width.
- W, 9, instruction width.
- CW, 16, cycle-counter width.
- HALT_OP, 9'h1FF, encoding that terminates the program.
- NOP_OP, 9'h000, encoding driven on instr_out during bubbles.

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; begins execution from IDLE.
- prog_ctr  in  D  current PC value from the program counter.
- instr_in  in  W  instruction ROM read data for prog_ctr (combinational ROM).
- stall  in  1  decode/hazard request to hold fetch this cycle.
- jump_en  in  1  taken branch resolved this cycle; squash the word being fetched.
- pc_stall  out  1  hold request to the program counter; PC must not advance while high.
- instr_out  out  W  registered instruction to decode.
- pc_out  out  D  registered PC of instr_out.
- valid_out  out  1  instr_out is a real instruction.
- done  out  1  program has halted; sticky.
- cycle_cnt  out  CW  RUN-state cycle count.

Behaviour:
- Reset (asynchronous, effective immediately, including mid-operation):
  - state = IDLE;
  - instr_out = NOP_OP; pc_out = 0; valid_out = 0; done = 0; cycle_cnt = 0.
- FSM states: IDLE, RUN, HALTED.
  - IDLE -> RUN on start. In RUN, start is ignored.
  - RUN -> HALTED when HALT_OP is captured (rules below).
  - HALTED is exited only by reset. start is ignored in HALTED.
- pc_stall is combinational: (state != RUN) | (stall & ~jump_en).
  - Consequence: the PC holds at its reset value until start is seen.
- Capture rules in RUN, on each rising edge:
  - jump_en = 1 (flush wins over stall): instr_out <= NOP_OP, valid_out <= 0, pc_out <= prog_ctr. The word at prog_ctr is discarded.
  - stall = 1, jump_en = 0: instr_out, pc_out and valid_out all hold.
  - Otherwise: instr_out <= instr_in, pc_out <= prog_ctr, valid_out <= 1.
- Latency: one cycle from prog_ctr/instr_in to instr_out/pc_out.
- Halt detection:
  - Applies only to a normal capture (no stall, no flush) where instr_in == HALT_OP.
  - That cycle the halt word is presented on instr_out with valid_out = 1, the state becomes HALTED, and done = 1 from the same edge.
  - A flushed or stalled HALT_OP does not halt.
- HALTED behaviour:
  - valid_out <= 0 and instr_out <= NOP_OP on the next edge; this state persists.
  - pc_stall = 1; done stays 1.
- IDLE behaviour: outputs keep their reset values; valid_out = 0.
- cycle_cnt:
  - Increments by 1 on every edge while in RUN, including stalled and flushed cycles and the halting edge.
  - Saturates at all-ones (no wrap).
  - Frozen in IDLE and HALTED.
- Simultaneous start and stall in IDLE: transition to RUN. The first capture occurs on the following edge, subject to stall then.
- Unsigned arithmetic only. No internal width extension beyond CW.

Decomposition:
- Package fetch_pkg:
  - state enum fetch_state_t {IDLE, RUN, HALTED};
  - default HALT_OP and NOP_OP localparams, shared with the decoder and assembler-facing tests.
- One natural sub-module: sat_counter (parameter CW; ports clk, reset, en, count). It is instantiated for cycle_cnt with en = (state == RUN).
- FSM and pipeline register remain in fetch_stage.

Test Plan:
- Reset, then start at cycle 2, ROM words 0x011, 0x022, 0x033:
  - pc_stall is 1 before start and 0 after;
  - instr_out is 0x011/pc 0 one cycle after entering RUN, then 0x022/pc 1, each with valid_out = 1.
- Stall held 3 cycles while instr_out = 0x022/pc 1:
  - outputs are held for 3 cycles and pc_stall = 1;
  - 0x033/pc 2 appears on the first edge after stall drops;
  - cycle_cnt advanced by 3 during the stall.
- Stall and jump_en both asserted in the same cycle, with prog_ctr = 5:
  - next cycle valid_out = 0, instr_out = 0x000, pc_out = 5;
  - pc_stall is 0 during that cycle.
- Fetch HALT_OP 0x1FF at pc 7:
  - instr_out = 0x1FF, valid_out = 1, done = 1 on the same edge;
  - the following cycle valid_out = 0;
  - cycle_cnt frozen thereafter, and start is ignored.
- HALT_OP fetched with jump_en = 1: no halt, done stays 0, a bubble is inserted.
- Preload near saturation (CW = 4 variant), run 20 cycles: cycle_cnt stops at 15.
- Assert reset asynchronously, mid-clock, while in RUN: all outputs reach reset values before the next edge, and state returns to IDLE.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and default opcodes for the instruction-fetch stage.
// The decoder and the assembler-facing tests use the same opcode defaults.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam int unsigned FETCH_W_DEFAULT = 9;
    localparam logic [FETCH_W_DEFAULT-1:0] HALT_OP_DEFAULT = 9'h1FF;
    localparam logic [FETCH_W_DEFAULT-1:0] NOP_OP_DEFAULT  = 9'h000;

endpackage

// File: rtl/fetch_stage_sat_counter.sv
// Saturating up-counter: advances by one when enabled and sticks at all-ones.
module sat_counter #(
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en && (count_q != CNT_MAX)) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Fetch pipeline register between PC/instruction ROM and decode, with a
// run/halt FSM, stall hold, branch-flush bubbles and a RUN-state cycle counter.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned   D       = 12,
    parameter int unsigned   W       = 9,
    parameter int unsigned   CW      = 16,
    parameter logic [W-1:0]  HALT_OP = W'(HALT_OP_DEFAULT),
    parameter logic [W-1:0]  NOP_OP  = W'(NOP_OP_DEFAULT)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [D-1:0]  prog_ctr,
    input  logic [W-1:0]  instr_in,
    input  logic          stall,
    input  logic          jump_en,
    output logic          pc_stall,
    output logic [W-1:0]  instr_out,
    output logic [D-1:0]  pc_out,
    output logic          valid_out,
    output logic          done,
    output logic [CW-1:0] cycle_cnt
);

    fetch_state_t state_q, state_d;
    logic [W-1:0] instr_q, instr_d;
    logic [D-1:0] pc_q,    pc_d;
    logic         valid_q, valid_d;
    logic         done_q,  done_d;
    logic         run_en;

    // Next-state and capture logic; flush takes priority over stall.
    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        pc_d     = pc_q;
        valid_d  = valid_q;
        done_d   = done_q;
        pc_stall = 1'b1;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                pc_stall = stall & ~jump_en;
                if (jump_en) begin
                    instr_d = NOP_OP;
                    valid_d = 1'b0;
                    pc_d    = prog_ctr;
                end else if (!stall) begin
                    instr_d = instr_in;
                    pc_d    = prog_ctr;
                    valid_d = 1'b1;
                    if (instr_in == HALT_OP) begin
                        state_d = HALTED;
                        done_d  = 1'b1;
                    end
                end
            end
            HALTED: begin
                // Halt word was shown for one cycle; bubble from here on.
                instr_d = NOP_OP;
                valid_d = 1'b0;
                done_d  = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            instr_q <= NOP_OP;
            pc_q    <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign run_en = (state_q == RUN);

    sat_counter #(
        .CW (CW)
    ) u_cycle_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (run_en),
        .count (cycle_cnt)
    );

    assign instr_out = instr_q;
    assign pc_out    = pc_q;
    assign valid_out = valid_q;
    assign done      = done_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: start, stall, flush, halt, saturation, async reset.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        start;
    logic [11:0] prog_ctr;
    logic [8:0]  instr_in;
    logic        stall;
    logic        jump_en;
    logic        pc_stall;
    logic [8:0]  instr_out;
    logic [11:0] pc_out;
    logic        valid_out;
    logic        done;
    logic [15:0] cycle_cnt;

    logic        start2;
    logic [11:0] prog_ctr2;
    logic [8:0]  instr_in2;
    logic        stall2;
    logic        jump_en2;
    logic        pc_stall2;
    logic [8:0]  instr_out2;
    logic [11:0] pc_out2;
    logic        valid_out2;
    logic        done2;
    logic [3:0]  cycle_cnt2;

    int total;
    int bad;

    fetch_stage dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .prog_ctr  (prog_ctr),
        .instr_in  (instr_in),
        .stall     (stall),
        .jump_en   (jump_en),
        .pc_stall  (pc_stall),
        .instr_out (instr_out),
        .pc_out    (pc_out),
        .valid_out (valid_out),
        .done      (done),
        .cycle_cnt (cycle_cnt)
    );

    fetch_stage #(.CW(4)) dut4 (
        .clk       (clk),
        .reset     (reset),
        .start     (start2),
        .prog_ctr  (prog_ctr2),
        .instr_in  (instr_in2),
        .stall     (stall2),
        .jump_en   (jump_en2),
        .pc_stall  (pc_stall2),
        .instr_out (instr_out2),
        .pc_out    (pc_out2),
        .valid_out (valid_out2),
        .done      (done2),
        .cycle_cnt (cycle_cnt2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        start     = 1'b0;
        prog_ctr  = 12'd0;
        instr_in  = 9'h011;
        stall     = 1'b0;
        jump_en   = 1'b0;
        start2    = 1'b0;
        prog_ctr2 = 12'd0;
        instr_in2 = 9'h011;
        stall2    = 1'b0;
        jump_en2  = 1'b0;

        tick();
        tick();
        check("rst_instr", 32'(instr_out), 32'h000);
        check("rst_pc",    32'(pc_out),    32'h0);
        check("rst_valid", 32'(valid_out), 32'h0);
        check("rst_done",  32'(done),      32'h0);
        check("rst_cnt",   32'(cycle_cnt), 32'h0);
        check("rst_pcstl", 32'(pc_stall),  32'h1);

        reset = 1'b0;
        tick();
        check("idle_pcstl", 32'(pc_stall),  32'h1);
        check("idle_valid", 32'(valid_out), 32'h0);

        // start pulse; RUN from the next edge
        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
        check("run_pcstl", 32'(pc_stall),  32'h0);
        check("run_cnt0",  32'(cycle_cnt), 32'h0);
        check("run_valid0", 32'(valid_out), 32'h0);

        tick();
        check("f0_instr", 32'(instr_out), 32'h011);
        check("f0_pc",    32'(pc_out),    32'h0);
        check("f0_valid", 32'(valid_out), 32'h1);
        check("f0_cnt",   32'(cycle_cnt), 32'h1);
        prog_ctr = 12'd1;
        instr_in = 9'h022;

        tick();
        check("f1_instr", 32'(instr_out), 32'h022);
        check("f1_pc",    32'(pc_out),    32'h1);
        check("f1_valid", 32'(valid_out), 32'h1);
        check("f1_cnt",   32'(cycle_cnt), 32'h2);

        // three stalled cycles hold 0x022/pc1
        prog_ctr = 12'd2;
        instr_in = 9'h033;
        stall    = 1'b1;
        #1;
        check("stl_pcstl", 32'(pc_stall), 32'h1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stl_instr", 32'(instr_out), 32'h022);
            check("stl_pc",    32'(pc_out),    32'h1);
            check("stl_valid", 32'(valid_out), 32'h1);
            check("stl_pcstl2", 32'(pc_stall), 32'h1);
        end
        check("stl_cnt", 32'(cycle_cnt), 32'h5);
        stall = 1'b0;

        tick();
        check("f2_instr", 32'(instr_out), 32'h033);
        check("f2_pc",    32'(pc_out),    32'h2);
        check("f2_valid", 32'(valid_out), 32'h1);
        check("f2_cnt",   32'(cycle_cnt), 32'h6);

        // stall and flush together: flush wins
        prog_ctr = 12'd5;
        instr_in = 9'h044;
        stall    = 1'b1;
        jump_en  = 1'b1;
        #1;
        check("fl_pcstl", 32'(pc_stall), 32'h0);
        tick();
        check("fl_instr", 32'(instr_out), 32'h000);
        check("fl_pc",    32'(pc_out),    32'h5);
        check("fl_valid", 32'(valid_out), 32'h0);
        check("fl_cnt",   32'(cycle_cnt), 32'h7);

        // flushed HALT_OP does not halt
        stall    = 1'b0;
        prog_ctr = 12'd6;
        instr_in = 9'h1FF;
        tick();
        check("fh_instr", 32'(instr_out), 32'h000);
        check("fh_pc",    32'(pc_out),    32'h6);
        check("fh_valid", 32'(valid_out), 32'h0);
        check("fh_done",  32'(done),      32'h0);
        check("fh_cnt",   32'(cycle_cnt), 32'h8);

        // stalled HALT_OP does not halt either
        jump_en = 1'b0;
        stall   = 1'b1;
        tick();
        check("sh_instr", 32'(instr_out), 32'h000);
        check("sh_valid", 32'(valid_out), 32'h0);
        check("sh_done",  32'(done),      32'h0);
        check("sh_cnt",   32'(cycle_cnt), 32'h9);

        // real halt at pc 7
        stall    = 1'b0;
        prog_ctr = 12'd7;
        tick();
        check("h_instr", 32'(instr_out), 32'h1FF);
        check("h_pc",    32'(pc_out),    32'h7);
        check("h_valid", 32'(valid_out), 32'h1);
        check("h_done",  32'(done),      32'h1);
        check("h_cnt",   32'(cycle_cnt), 32'hA);
        check("h_pcstl", 32'(pc_stall),  32'h1);

        start    = 1'b1;
        prog_ctr = 12'd8;
        instr_in = 9'h055;
        tick();
        start = 1'b0;
        check("ha_valid", 32'(valid_out), 32'h0);
        check("ha_instr", 32'(instr_out), 32'h000);
        check("ha_done",  32'(done),      32'h1);
        check("ha_cnt",   32'(cycle_cnt), 32'hA);
        tick();
        tick();
        check("hb_cnt",   32'(cycle_cnt), 32'hA);
        check("hb_done",  32'(done),      32'h1);
        check("hb_valid", 32'(valid_out), 32'h0);
        check("hb_pcstl", 32'(pc_stall),  32'h1);

        // restart via reset, then async reset mid-cycle while in RUN
        reset = 1'b1;
        #1;
        check("r2_done", 32'(done), 32'h0);
        tick();
        reset    = 1'b0;
        prog_ctr = 12'd3;
        instr_in = 9'h066;
        start    = 1'b1;
        start2   = 1'b1;
        tick();
        start  = 1'b0;
        start2 = 1'b0;
        tick();
        check("ar_pre_instr", 32'(instr_out), 32'h066);
        check("ar_pre_valid", 32'(valid_out), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check("ar_instr", 32'(instr_out), 32'h000);
        check("ar_pc",    32'(pc_out),    32'h0);
        check("ar_valid", 32'(valid_out), 32'h0);
        check("ar_done",  32'(done),      32'h0);
        check("ar_cnt",   32'(cycle_cnt), 32'h0);
        check("ar_pcstl", 32'(pc_stall),  32'h1);
        tick();
        reset = 1'b0;
        tick();
        check("ar_idle_cnt",   32'(cycle_cnt), 32'h0);
        check("ar_idle_pcstl", 32'(pc_stall),  32'h1);

        // CW=4 instance: 20 RUN cycles saturate at 15
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        check("sat_14", 32'(cycle_cnt2), 32'hE);
        for (int i = 0; i < 6; i++) tick();
        check("sat_20", 32'(cycle_cnt2), 32'hF);
        check("sat_run", 32'(pc_stall2), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
